// File: rtl/aes_out_route.sv
// rtl/aes_out_route.sv - captures an AES result block, streams it out as words and drives the chain select
module aes_out_route #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aes_done,
  input  logic [127:0]      aes_out,
  input  logic              chain_en,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              d_tk,
  output logic              busy,
  output logic [7:0]        blk_cnt,
  output logic              overrun
);

  localparam int NWORDS = 128 / WORD_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]       state;
  logic [127:0]     buffer;
  logic [IDX_W-1:0] idx;
  logic             handshake;
  logic             last_word;

  // Word 0 is the most significant slice of the block.
  logic [WORD_W-1:0] words [NWORDS];

  for (genvar i = 0; i < NWORDS; i++) begin : g_words
    assign words[i] = buffer[127 - i*WORD_W -: WORD_W];
  end

  assign out_data  = words[idx];
  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign handshake = out_valid && out_ready;
  assign last_word = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      buffer  <= '0;
      idx     <= '0;
      d_tk    <= 1'b0;
      blk_cnt <= 8'd0;
      overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aes_done) begin
            buffer  <= aes_out;
            idx     <= '0;
            d_tk    <= chain_en;
            blk_cnt <= blk_cnt + 8'd1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (handshake && last_word) begin
            // A result arriving on the final handshake is taken back-to-back, not dropped.
            idx <= '0;
            if (aes_done) begin
              buffer  <= aes_out;
              d_tk    <= chain_en;
              blk_cnt <= blk_cnt + 8'd1;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (handshake) begin
              idx <= idx + 1'b1;
            end
            if (aes_done) begin
              overrun <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_out_route.sv
// tb/tb_aes_out_route.sv - directed self-checking bench for aes_out_route
module tb_aes_out_route;

  logic         clk;
  logic         rst;
  logic         aes_done;
  logic [127:0] aes_out;
  logic         chain_en;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         d_tk;
  logic         busy;
  logic [7:0]   blk_cnt;
  logic         overrun;

  int total;
  int bad;

  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_B = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;

  logic [31:0] wa [4];
  logic [31:0] wb [4];

  aes_out_route #(.WORD_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .aes_done (aes_done),
    .aes_out  (aes_out),
    .chain_en (chain_en),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .d_tk     (d_tk),
    .busy     (busy),
    .blk_cnt  (blk_cnt),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [127:0] blk, input logic chain);
    aes_out  = blk;
    chain_en = chain;
    aes_done = 1'b1;
    tick();
    aes_done = 1'b0;
    aes_out  = {4{$urandom}};
  endtask

  task automatic drain_a(input string tag, input int first);
    out_ready = 1'b1;
    for (int i = first; i < 4; i++) begin
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_word"}, out_data, wa[i]);
      tick();
    end
  endtask

  task automatic drain_b(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_word"}, out_data, wb[i]);
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    wa = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    wb = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98};
    rst = 1'b1;
    aes_done = 1'b0;
    aes_out = '0;
    chain_en = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", out_data, 0);
    chk("rst_cnt", blk_cnt, 0);
    chk("rst_dtk", d_tk, 0);
    chk("rst_ovr", overrun, 0);

    // ready asserted in IDLE must not start anything
    out_ready = 1'b1;
    aes_out = BLK_B;
    tick();
    tick();
    chk("idle_ready_valid", out_valid, 0);
    chk("idle_ready_cnt", blk_cnt, 0);

    // basic drain
    capture(BLK_A, 1'b0);
    drain_a("basic", 0);
    chk("basic_idle", out_valid, 0);
    chk("basic_busy", busy, 0);
    chk("basic_cnt", blk_cnt, 1);
    chk("basic_dtk", d_tk, 0);

    // backpressure
    out_ready = 1'b0;
    capture(BLK_A, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_hold", out_data, 32'h00112233);
      tick();
    end
    drain_a("bp", 0);
    chk("bp_idle", out_valid, 0);
    chk("bp_cnt", blk_cnt, 2);

    // chaining
    capture(BLK_A, 1'b1);
    chk("chain_dtk1", d_tk, 1);
    drain_a("chain1", 0);
    chk("chain_idle_hold", d_tk, 1);
    capture(BLK_B, 1'b0);
    chk("chain_dtk0", d_tk, 0);
    drain_b("chain2");
    chk("chain_cnt", blk_cnt, 4);

    // overrun: new result during word 1 with no handshake
    capture(BLK_A, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    aes_out = BLK_B;
    chain_en = 1'b1;
    aes_done = 1'b1;
    tick();
    aes_done = 1'b0;
    chk("ovr_flag", overrun, 1);
    chk("ovr_cnt", blk_cnt, 5);
    chk("ovr_dtk", d_tk, 0);
    chk("ovr_word1", out_data, wa[1]);
    drain_a("ovr", 1);
    chk("ovr_idle", out_valid, 0);
    chk("ovr_sticky", overrun, 1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_ovr", overrun, 0);
    chk("rst2_cnt", blk_cnt, 0);

    // back-to-back capture on the final handshake
    capture(BLK_A, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("b2b_word", out_data, wa[i]);
      tick();
    end
    chk("b2b_word3", out_data, wa[3]);
    aes_out = BLK_B;
    chain_en = 1'b1;
    aes_done = 1'b1;
    tick();
    aes_done = 1'b0;
    chk("b2b_valid", out_valid, 1);
    chk("b2b_newword0", out_data, wb[0]);
    chk("b2b_ovr", overrun, 0);
    chk("b2b_cnt", blk_cnt, 2);
    chk("b2b_dtk", d_tk, 1);
    drain_b("b2b");
    chk("b2b_idle", busy, 0);

    // reset mid-operation, with overrun and d_tk set
    capture(BLK_A, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    aes_done = 1'b1;
    tick();
    aes_done = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("mid_word2", out_data, wa[2]);
    chk("mid_ovr_pre", overrun, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_valid", out_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_cnt", blk_cnt, 0);
    chk("mid_dtk", d_tk, 0);
    chk("mid_ovr", overrun, 0);
    chk("mid_data", out_data, 0);
    tick();
    chk("mid_stay_idle", out_valid, 0);

    // counter wrap
    out_ready = 1'b1;
    for (int n = 0; n < 256; n++) begin
      capture(BLK_B, 1'b0);
      for (int k = 0; k < 4; k++) tick();
      if (n == 254) chk("wrap_255", blk_cnt, 255);
    end
    chk("wrap_0", blk_cnt, 0);
    chk("wrap_ovr", overrun, 0);
    chk("wrap_idle", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_out_route.md
AES_OUT_ROUTE -- requirements
Module: aes_out_route

Interface
REQ-001 SHALL have parameter WORD_W, default 32, output word width; 128 SHALL be divisible by WORD_W; NWORDS = 128/WORD_W.
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port aes_done  input  1  one-cycle pulse; aes_out valid this cycle.
REQ-005 SHALL have port aes_out  input  128  AES core result block.
REQ-006 SHALL have port chain_en  input  1  sampled at capture; 1 = result feeds next AES input.
REQ-007 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-008 SHALL have port out_data  output  WORD_W  current output word.
REQ-009 SHALL have port out_valid  output  1  out_data valid.
REQ-010 SHALL have port d_tk  output  1  route select to the AES input mux; 1 = feed result back, 0 = take new input.
REQ-011 SHALL have port busy  output  1  block captured, not fully drained.
REQ-012 SHALL have port blk_cnt  output  8  count of captured blocks.
REQ-013 SHALL have port overrun  output  1  sticky flag; a result was dropped.

Function
REQ-014 SHALL implement a two-state FSM, IDLE and SEND; busy = (state == SEND); out_valid = (state == SEND).
REQ-015 IDLE with aes_done=1 SHALL, at that edge: capture aes_out into a 128-bit buffer, set word index to 0, set d_tk to chain_en, increment blk_cnt, and enter SEND.
REQ-016 out_valid SHALL therefore rise one cycle after aes_done (latency 1).
REQ-017 out_data SHALL be buffer word idx, most significant first: idx 0 = bits [127:128-WORD_W].
REQ-018 A handshake SHALL occur when out_valid && out_ready; at each handshake idx SHALL increment.
REQ-019 A handshake with idx = NWORDS-1 and aes_done=0 SHALL return the FSM to IDLE and reset idx to 0.
REQ-020 A handshake with idx = NWORDS-1 and aes_done=1 in the same cycle SHALL capture the new block as in REQ-015 and stay in SEND; overrun SHALL NOT be set.
REQ-021 aes_done in SEND without a final handshake SHALL drop the new result and set overrun. Buffer, idx, d_tk and blk_cnt SHALL be unchanged.
REQ-022 overrun SHALL stay 1 until rst.
REQ-023 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 out_ready in IDLE SHALL have no effect.
REQ-025 blk_cnt SHALL wrap from 255 to 0 without any flag.
REQ-026 d_tk SHALL hold its value between captures, including in IDLE.
REQ-027 aes_out SHALL be ignored when aes_done=0.

Reset
REQ-028 rst=1 at a clock edge SHALL force state IDLE, idx 0, buffer 0, d_tk 0, blk_cnt 0, overrun 0. As a result out_valid=0, busy=0 and out_data=0.
REQ-029 rst SHALL take priority over all other inputs, including mid-SEND. A partially drained block SHALL be discarded and no further words presented.

Verification
REQ-030 Basic drain: aes_out=0x00112233_44556677_8899AABB_CCDDEEFF, aes_done pulse, chain_en=0, out_ready=1 -> out_valid from next cycle for 4 cycles; words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF; then IDLE; blk_cnt=1; d_tk=0.
REQ-031 Backpressure: same block, out_ready low for 3 cycles after out_valid rises -> out_data holds 0x00112233 those cycles; all 4 words still delivered in order.
REQ-032 Chaining: capture with chain_en=1 -> d_tk=1 from the cycle after aes_done; next capture with chain_en=0 -> d_tk=0.
REQ-033 Overrun versus back-to-back: aes_done during word 1 -> overrun=1, original 4 words intact, blk_cnt unchanged. Separately, aes_done coincident with the word-3 handshake -> new block word 0 presented next cycle, overrun=0.
REQ-034 Reset mid-operation: rst during word 2 -> next cycle out_valid=0, busy=0, blk_cnt=0, d_tk=0, overrun=0.
REQ-035 Counter wrap: 256 captures -> blk_cnt returns to 0.
